debounce_repeat: RTL

- Multi-channel debouncer with auto-repeat.
- Sits directly downstream of the input synchroniser: it consumes the already-synchronised button/switch vector and produces clean levels plus single-cycle press, release and repeat pulses.
- Downstream logic (menu/UI FSMs, counters) uses the pulses directly, with no further one-shot stage.
- All channels are independent and share one clock.

---
 rtl/debounce_repeat.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/debounce_repeat.sv
// rtl/debounce_repeat.sv - multi-channel debouncer with press/release/auto-repeat pulses
//
// Purpose:
//   Consumes an already-synchronised button/switch vector and produces a clean
//   debounced level per channel plus single-cycle press, release and
//   auto-repeat pulses. Every channel is independent and all share one clock.
//
// Ports:
//   clk            in   1      system clock, all logic on the rising edge
//   rst            in   1      synchronous active-low reset (0 = reset)
//   en             in   1      enable; when 0 counters clear, level holds, no pulses
//   sync_in        in   WIDTH  synchronised raw inputs, 1 = pressed
//   level          out  WIDTH  debounced level per channel
//   press          out  WIDTH  1-cycle pulse when level rises
//   release_pulse  out  WIDTH  1-cycle pulse when level falls
//   repeat_pulse   out  WIDTH  1-cycle auto-repeat pulse while level is held high
//
//   The release and repeat outputs carry a _pulse suffix because "release" and
//   "repeat" are reserved words in SystemVerilog.

module debounce_repeat #(
    parameter int          WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] repeat_pulse
);

    // Terminal counts: a counter that has reached *_LAST on the current edge
    // completes its interval on that edge.
    localparam logic [31:0] STABLE_LAST = 32'(STABLE_CYCLES - 1);
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = (REPEAT_PERIOD == 0) ? 32'd0 : 32'(REPEAT_PERIOD - 1);
    localparam logic        REPEAT_ON   = (REPEAT_PERIOD != 0);

    // Auto-repeat per channel: IDLE while released; HELD is split into the
    // initial-delay phase and the periodic phase.
    typedef enum logic [1:0] {
        REP_IDLE     = 2'd0,
        REP_DELAY    = 2'd1,
        REP_PERIODIC = 2'd2
    } rep_state_t;

    logic [31:0] deb_cnt   [WIDTH];
    logic [31:0] rep_cnt   [WIDTH];
    rep_state_t  rep_state [WIDTH];

    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rep_hit;
    logic [WIDTH-1:0] rep_fire;

    always_comb begin
        mismatch = '0;
        flip     = '0;
        rise     = '0;
        fall     = '0;
        rep_hit  = '0;
        rep_fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mismatch[i] = (sync_in[i] != level[i]);
            // level flips on the STABLE_CYCLES-th consecutive mismatching edge
            flip[i]     = en && mismatch[i] && (deb_cnt[i] == STABLE_LAST);
            rise[i]     = flip[i] && sync_in[i];
            fall[i]     = flip[i] && !sync_in[i];
            case (rep_state[i])
                REP_DELAY:    rep_hit[i] = (rep_cnt[i] == DELAY_LAST);
                REP_PERIODIC: rep_hit[i] = (rep_cnt[i] == PERIOD_LAST);
                default:      rep_hit[i] = 1'b0;
            endcase
            // A falling edge wins over a due repeat: no repeat on the release cycle.
            rep_fire[i] = en && REPEAT_ON && rep_hit[i] && !fall[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            repeat_pulse  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                deb_cnt[i]   <= 32'd0;
                rep_cnt[i]   <= 32'd0;
                rep_state[i] <= REP_IDLE;
            end
        end else begin
            // rise/fall/rep_fire are already gated by en, so pulses drop to 0
            // while disabled.
            press         <= rise;
            release_pulse <= fall;
            repeat_pulse  <= rep_fire;
            for (int i = 0; i < WIDTH; i++) begin
                if (!en) begin
                    deb_cnt[i]   <= 32'd0;
                    rep_cnt[i]   <= 32'd0;
                    // A held channel restarts from the initial repeat delay.
                    rep_state[i] <= level[i] ? REP_DELAY : REP_IDLE;
                end else begin
                    if (!mismatch[i]) begin
                        deb_cnt[i] <= 32'd0;
                    end else if (flip[i]) begin
                        deb_cnt[i] <= 32'd0;
                        level[i]   <= sync_in[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 32'd1;
                    end

                    case (rep_state[i])
                        REP_IDLE: begin
                            rep_cnt[i] <= 32'd0;
                            if (rise[i]) begin
                                rep_state[i] <= REP_DELAY;
                            end
                        end
                        REP_DELAY, REP_PERIODIC: begin
                            if (fall[i]) begin
                                rep_state[i] <= REP_IDLE;
                                rep_cnt[i]   <= 32'd0;
                            end else if (!REPEAT_ON) begin
                                rep_cnt[i]   <= 32'd0;
                            end else if (rep_hit[i]) begin
                                rep_state[i] <= REP_PERIODIC;
                                rep_cnt[i]   <= 32'd0;
                            end else begin
                                rep_cnt[i]   <= rep_cnt[i] + 32'd1;
                            end
                        end
                        default: begin
                            rep_state[i] <= REP_IDLE;
                            rep_cnt[i]   <= 32'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
